// File: rtl/alphacore_mem_if.sv
// alphacore_mem_if: alphacore native memory bus (core request / slave response).
// Signals:
//   mem_valid  - core request valid
//   mem_instr  - request is an instruction fetch
//   mem_addr   - byte address, bits [1:0] ignored
//   mem_wdata  - write data
//   mem_wstrb  - byte write enables, 0 = read
//   mem_ready  - one-cycle response pulse
//   mem_rdata  - read data, valid with mem_ready and held until the next response
// Modports: master (core side), slave (memory side).
interface alphacore_mem_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/alphacore_mem_ctrl.sv
// alphacore_mem_ctrl: on-chip word RAM slave for the alphacore native memory interface
module alphacore_mem_ctrl #(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] IO_ADDR     = 32'h1000_0000
) (
  input  logic           clk,
  input  logic           resetn,
  alphacore_mem_if.slave bus,
  output logic           bus_err
`ifdef MEM_IO_PORT_EN
  ,
  output logic [31:0]    io_out,
  output logic           io_strobe
`endif
);
  localparam int         AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef MEM_IO_PORT_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [29:0] a_word;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_instr;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [31:0] ram [MEM_WORDS];
  logic [31:0] io_val, old_word, merged;
  logic        accept, in_ram, is_io, err, is_write;
  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_range
      $error("alphacore_mem_ctrl: WAIT_STATES must be in 0..15");
    end
  endgenerate
  assign accept   = state == IDLE && bus.mem_valid && !ready_q;
  assign in_ram   = a_word < 30'(MEM_WORDS);
  assign is_io    = IO_EN && a_word == IO_ADDR[31:2];
  assign err      = (!in_ram && !is_io) || (a_instr && |a_wstrb);
  assign is_write = |a_wstrb && !err;
  assign old_word = is_io ? io_val : ram[a_word[AW-1:0]];
  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  always_comb begin
    next_state = (state == IDLE) ? (accept ? ((WS == 4'd0) ? RESP : WAIT) : IDLE) :
                 (state == WAIT) ? ((cnt == 4'd1) ? RESP : WAIT) : IDLE;
  end
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++)
      if (a_wstrb[i]) merged[8*i +: 8] = a_wdata[8*i +: 8];
  end
  always_ff @(posedge clk)
    if (state == RESP && is_write && !is_io) ram[a_word[AW-1:0]] <= merged;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      a_word  <= '0;
      a_wdata <= '0;
      a_wstrb <= '0;
      a_instr <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= state == RESP;
      if (accept) begin
        a_word  <= bus.mem_addr[31:2];
        a_wdata <= bus.mem_wdata;
        a_wstrb <= bus.mem_wstrb;
        a_instr <= bus.mem_instr;
        cnt     <= WS;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP) begin
        rdata_q <= err ? 32'h0 : old_word;
        bus_err <= bus_err | err;
      end
    end
  end
`ifdef MEM_IO_PORT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= state == RESP && is_io && is_write;
      if (state == RESP && is_io && is_write) io_out <= merged;
    end
  end
  assign io_val = io_out;
`else
  assign io_val = '0;
`endif
endmodule

// File: tb/tb_alphacore_mem_ctrl.sv
// tb_alphacore_mem_ctrl: randomized self-checking bench for alphacore_mem_ctrl against a word-array model.
module tb_alphacore_mem_ctrl;
    localparam int WS    = 3;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic bus_err;
`ifdef MEM_IO_PORT_EN
    logic [31:0] io_out;
    logic        io_strobe;
`endif
    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [DEPTH];

    alphacore_mem_if bus();

    alphacore_mem_ctrl #(.MEM_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus),
        .bus_err(bus_err)
`ifdef MEM_IO_PORT_EN
        ,
        .io_out(io_out),
        .io_strobe(io_strobe)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // One request; inputs are scrambled after acceptance to show the DUT latched them.
    // lat counts clock edges from the acceptance edge to the first cycle with mem_ready high.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic ins, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        bus.mem_instr = ins;
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = $urandom;
        bus.mem_wdata = $urandom;
        bus.mem_wstrb = 4'($urandom);
        bus.mem_instr = 1'($urandom);
        lat = 0;
        while (bus.mem_ready !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.mem_rdata;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", bus.mem_ready); end
        checks++; if (bus.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", bus.mem_rdata); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
`ifdef MEM_IO_PORT_EN
        checks++; if (io_out !== 32'h0 || io_strobe !== 1'b0) begin failures++; $display("FAIL reset_io: got %h/%b expected 0/0", io_out, io_strobe); end
`endif
        resetn = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] rd;
        int lat;
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i] = $urandom;
            access(32'(i) << 2, mdl[i], 4'hF, 1'b0, rd, lat);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd;
        int lat;
        mdl[0] = 32'h3fc00093;
        access(32'h0, mdl[0], 4'hF, 1'b0, rd, lat);
        access(32'h0, 32'h0, 4'h0, 1'b1, rd, lat);
        checks++; if (lat !== WS + 1) begin failures++; $display("FAIL read_latency: got %0d expected %0d", lat, WS + 1); end
        checks++; if (rd !== 32'h3fc00093) begin failures++; $display("FAIL read_word0: got %h expected 3fc00093", rd); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL read_bus_err: got %b expected 0", bus_err); end
        @(posedge clk); #1;
        checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL ready_one_cycle: got %b expected 0", bus.mem_ready); end
        checks++; if (bus.mem_rdata !== 32'h3fc00093) begin failures++; $display("FAIL rdata_held: got %h expected 3fc00093", bus.mem_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp;
        logic [3:0]  s;
        logic        ins;
        int          lat, bad_rd = 0, bad_lat = 0;
        for (int n = 0; n < 60; n++) begin
            a   = {22'd0, 8'($urandom), 2'($urandom)};
            d   = $urandom;
            s   = 4'($urandom);
            ins = (s == 4'h0) ? 1'($urandom) : 1'b0;
            exp = mdl[a[9:2]];
            mdl[a[9:2]] = lanes(exp, d, s);
            access(a, d, s, ins, rd, lat);
            checks++;
            if (rd !== exp) begin
                failures++;
                $display("FAIL random_rdata[%0d] addr=%h strb=%h: got %h expected %h", n, a, s, rd, exp);
            end
            if (lat != WS + 1) bad_lat++;
        end
        checks++; if (bad_lat != 0) begin failures++; $display("FAIL random_latency: %0d of 60 responses late or early", bad_lat); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL random_bus_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int lat;
        access(32'h3FC, 32'h11223344, 4'hF, 1'b0, rd, lat);
        access(32'h3FC, 32'hAABBCCDD, 4'b0011, 1'b0, rd, lat);
        checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL lanes_old_word: got %h expected 11223344", rd); end
        access(32'h3FC, 32'h0, 4'h0, 1'b0, rd, lat);
        checks++; if (rd !== 32'h1122CCDD) begin failures++; $display("FAIL lanes_merged: got %h expected 1122ccdd", rd); end
        access(32'h3FC, 32'h55667788, 4'b1100, 1'b0, rd, lat);
        access(32'h3FC, 32'h0, 4'h0, 1'b0, rd, lat);
        checks++; if (rd !== 32'h5566CCDD) begin failures++; $display("FAIL lanes_upper: got %h expected 5566ccdd", rd); end
        mdl[255] = 32'h5566CCDD;
    endtask

    // mem_valid stays high across three writes; a new request may only be taken
    // after the idle cycle following each response, so pulses are WS+3 cycles apart.
    task automatic test_back_to_back();
        logic [31:0] init, rd;
        int pulses = 0, last = -1, cyc = 0, lat, bad_gap = 0, bad_rd = 0;
        init = mdl[255];
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h3FC;
        bus.mem_wdata = init + 32'd1;
        bus.mem_wstrb = 4'hF;
        bus.mem_instr = 1'b0;
        while (pulses < 3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mem_ready === 1'b1) begin
                if (bus.mem_rdata !== init + 32'(pulses)) bad_rd++;
                if (last >= 0 && cyc - last != WS + 3) bad_gap++;
                last = cyc;
                pulses++;
                bus.mem_wdata = init + 32'(pulses) + 32'd1;
            end
        end
        bus.mem_valid = 1'b0;
        repeat (2 * WS + 6) begin
            @(posedge clk); #1;
            if (bus.mem_ready === 1'b1) pulses++;
        end
        checks++; if (pulses != 3) begin failures++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
        checks++; if (bad_gap != 0) begin failures++; $display("FAIL b2b_gap: %0d gaps differ from %0d cycles", bad_gap, WS + 3); end
        checks++; if (bad_rd != 0) begin failures++; $display("FAIL b2b_rdata: %0d responses had wrong old word", bad_rd); end
        mdl[255] = init + 32'd3;
        access(32'h3FC, 32'h0, 4'h0, 1'b0, rd, lat);
        checks++; if (rd !== init + 32'd3) begin failures++; $display("FAIL b2b_final: got %h expected %h", rd, init + 32'd3); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        int lat, bad = 0;
        pulse_reset();
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b expected 0", bus_err); end
        access(32'h20, 32'hDEADBEEF, 4'hF, 1'b1, rd, lat);
        checks++; if (lat !== WS + 1 || rd !== 32'h0) begin failures++; $display("FAIL instr_write_resp: got lat=%0d rd=%h expected lat=%0d rd=0", lat, rd, WS + 1); end
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL instr_write_err: got %b expected 1", bus_err); end
        access(32'h20, 32'h0, 4'h0, 1'b0, rd, lat);
        checks++; if (rd !== mdl[8]) begin failures++; $display("FAIL instr_write_dropped: got %h expected %h", rd, mdl[8]); end
        pulse_reset();
        access(32'h400, 32'h0, 4'h0, 1'b0, rd, lat);
        checks++; if (lat !== WS + 1 || rd !== 32'h0) begin failures++; $display("FAIL oor_read_resp: got lat=%0d rd=%h expected lat=%0d rd=0", lat, rd, WS + 1); end
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL oor_read_err: got %b expected 1", bus_err); end
        access(32'h400, 32'h12345678, 4'hF, 1'b0, rd, lat);
        for (int n = 0; n < 10; n++) begin
            access(32'(n) << 2, 32'h0, 4'h0, 1'b0, rd, lat);
            if (rd !== mdl[n]) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL oor_write_dropped: %0d of 10 words differ", bad); end
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", bus_err); end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int lat, seen = 0;
        mdl[2] = 32'h0BADF00D;
        access(32'h8, mdl[2], 4'hF, 1'b0, rd, lat);
        access(32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h8;
        bus.mem_wdata = 32'hFFFFFFFF;
        bus.mem_wstrb = 4'hF;
        bus.mem_instr = 1'b0;
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        checks++; if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: got ready=%b rdata=%h err=%b expected 0/0/0", bus.mem_ready, bus.mem_rdata, bus_err);
        end
`ifdef MEM_IO_PORT_EN
        checks++; if (io_out !== 32'h0 || io_strobe !== 1'b0) begin failures++; $display("FAIL abort_io: got %h/%b expected 0/0", io_out, io_strobe); end
`endif
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.mem_ready === 1'b1) seen++;
        end
        resetn = 1'b1;
        repeat (WS + 4) begin
            @(posedge clk); #1;
            if (bus.mem_ready === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_ready: got %0d pulses expected 0", seen); end
        access(32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL abort_no_write: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_io();
        logic [31:0] rd;
        int lat;
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL io_pre_err: got %b expected 0", bus_err); end
        access(32'h1000_0000, 32'h5, 4'hF, 1'b0, rd, lat);
`ifdef MEM_IO_PORT_EN
        checks++; if (io_out !== 32'h5) begin failures++; $display("FAIL io_out: got %h expected 5", io_out); end
        checks++; if (io_strobe !== 1'b1) begin failures++; $display("FAIL io_strobe_with_ready: got %b expected 1", io_strobe); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL io_bus_err: got %b expected 0", bus_err); end
        @(posedge clk); #1;
        checks++; if (io_strobe !== 1'b0) begin failures++; $display("FAIL io_strobe_one_cycle: got %b expected 0", io_strobe); end
        access(32'h1000_0000, 32'h0, 4'h0, 1'b0, rd, lat);
        checks++; if (rd !== 32'h5) begin failures++; $display("FAIL io_read: got %h expected 5", rd); end
`else
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL io_absent_err: got %b expected 1", bus_err); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL io_absent_rdata: got %h expected 0", rd); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_latency();
        test_random();
        test_byte_lanes();
        test_back_to_back();
        test_errors();
        test_abort();
        test_io();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
